// File: rtl/seg_scan_capture.sv
// Read-back receiver for the multiplexed 7-segment bus: debounces each (AN, SEGMENT)
// dwell, decodes the glyph to a nibble and assembles four digits into a handshaked frame.
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  AN,
    input  logic [7:0]  SEGMENT,
    output logic [15:0] frame_value,
    output logic [3:0]  frame_dp,
    output logic [3:0]  frame_err,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overflow,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] COMPLETE = 2'd2;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] ACCEPT_AT  = 8'(STABLE_CYCLES - 1);

    // Handshake: frame_* outputs are valid while frame_valid=1 and hold until a cycle
    // with frame_ready=1; frame_ready is ignored while frame_valid=0.

    logic [3:0]  an_m, an_s;
    logic [7:0]  seg_m, seg_s;
    logic [11:0] prev_sample;
    logic [7:0]  cnt;
    logic        changed;
    logic        sel_ok;
    logic [1:0]  sel_idx;
    logic [6:0]  glyph;
    logic [3:0]  dec_nib;
    logic        dec_err;
    logic        accept;

    logic        wr;
    logic [1:0]  wr_idx;
    logic [3:0]  wr_nib;
    logic        wr_dp;
    logic        wr_err;

    logic [15:0] slot_value;
    logic [3:0]  slot_dp;
    logic [3:0]  slot_err;
    logic [3:0]  seen;
    logic [3:0]  seen_next;
    logic [1:0]  state;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m  <= 4'd0;
            an_s  <= 4'd0;
            seg_m <= 8'd0;
            seg_s <= 8'd0;
        end else begin
            an_m  <= AN;
            an_s  <= an_m;
            seg_m <= SEGMENT;
            seg_s <= seg_m;
        end
    end

    assign changed = ({an_s, seg_s} != prev_sample);

    // Saturating at STABLE_MAX guarantees the counter passes ACCEPT_AT once per dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample <= 12'd0;
            cnt         <= 8'd0;
        end else begin
            prev_sample <= {an_s, seg_s};
            if (changed)
                cnt <= 8'd0;
            else if (cnt != STABLE_MAX)
                cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (an_s)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    assign glyph = ~seg_s[6:0];

    always_comb begin
        dec_err = 1'b0;
        dec_nib = 4'h0;
        case (glyph)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_err = 1'b1;
        endcase
    end

    assign accept = !changed && (cnt == ACCEPT_AT) && sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr     <= 1'b0;
            wr_idx <= 2'd0;
            wr_nib <= 4'd0;
            wr_dp  <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr     <= accept;
            wr_idx <= sel_idx;
            wr_nib <= dec_nib;
            wr_dp  <= ~seg_s[7];
            wr_err <= dec_err;
        end
    end

    // A write landing in the COMPLETE cycle starts the next frame rather than being lost.
    always_comb begin
        seen_next = (state == COMPLETE) ? 4'b0000 : seen;
        if (wr)
            seen_next[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_value <= 16'd0;
            slot_dp    <= 4'd0;
            slot_err   <= 4'd0;
            seen       <= 4'd0;
            state      <= IDLE;
        end else begin
            if (wr) begin
                slot_value[{wr_idx, 2'b00} +: 4] <= wr_nib;
                slot_dp[wr_idx]                  <= wr_dp;
                slot_err[wr_idx]                 <= wr_err;
            end
            seen <= seen_next;
            if (seen_next == 4'b1111)
                state <= COMPLETE;
            else if (seen_next == 4'b0000)
                state <= IDLE;
            else
                state <= COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_value <= 16'd0;
            frame_dp    <= 4'd0;
            frame_err   <= 4'd0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (state == COMPLETE) begin
                if (!frame_valid || frame_ready) begin
                    frame_value <= slot_value;
                    frame_dp    <= slot_dp;
                    frame_err   <= slot_err;
                    frame_valid <= 1'b1;
                end else begin
                    overflow    <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed and randomized checks of seg_scan_capture against a glyph-table reference model.
module tb_seg_scan_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic [15:0] frame_value;
    logic [3:0]  frame_dp;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overflow;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_capture #(.STABLE_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .AN          (AN),
        .SEGMENT     (SEGMENT),
        .frame_value (frame_value),
        .frame_dp    (frame_dp),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overflow    (overflow),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame monitor used while the consumer is always ready.
    logic        mon_en = 1'b0;
    int          mon_pulses = 0;
    logic [15:0] mon_value = 16'd0;
    logic [3:0]  mon_dp = 4'd0;
    logic [3:0]  mon_err = 4'd0;

    always @(negedge clk) begin
        if (mon_en && frame_valid && frame_ready) begin
            mon_pulses = mon_pulses + 1;
            mon_value  = frame_value;
            mon_dp     = frame_dp;
            mon_err    = frame_err;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg_byte(input logic [3:0] nib, input logic dp);
        return {~dp, ~glyph[nib]};
    endfunction

    task automatic show(input logic [3:0] an, input logic [7:0] seg, input int n);
        AN = an;
        SEGMENT = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show_digit(input int idx, input logic [7:0] seg, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << idx);
        show(an, seg, n);
    endtask

    task automatic scan(input logic [15:0] value, input logic [3:0] dp, input int dwell);
        for (int i = 3; i >= 0; i--)
            show_digit(i, seg_byte(value[4*i +: 4], dp[i]), dwell);
        show(4'hF, 8'hFF, 10);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!frame_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {15'd0, frame_valid}, 16'd1);
    endtask

    task automatic consume(input string tag);
        @(posedge clk);
        #1 frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
        @(negedge clk);
        chk(tag, {15'd0, frame_valid}, 16'd0);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] dp,
                               input logic [3:0] err);
        chk({tag, "_value"}, frame_value, v);
        chk({tag, "_dp"}, {12'd0, frame_dp}, {12'd0, dp});
        chk({tag, "_err"}, {12'd0, frame_err}, {12'd0, err});
    endtask

    initial begin
        logic [15:0] exp_v;
        logic [3:0]  exp_dp;
        logic [3:0]  exp_err;
        logic [6:0]  pat [4];
        int          order [4];
        int          tmp;
        int          j;
        int          dwell;
        bit          found;

        rst_n = 1'b0;
        AN = 4'hF;
        SEGMENT = 8'hFF;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_value", frame_value, 16'h0000);
        chk("rst_dp", {12'd0, frame_dp}, 16'd0);
        chk("rst_err", {12'd0, frame_err}, 16'd0);
        chk("rst_valid", {15'd0, frame_valid}, 16'd0);
        chk("rst_overflow", {15'd0, overflow}, 16'd0);
        chk("rst_state", {14'd0, state_dbg}, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        show(4'hF, 8'hFF, 5);

        // Ideal scan with an always-ready consumer: one valid pulse per full scan.
        frame_ready = 1'b1;
        mon_en = 1'b1;
        scan(16'hABCD, 4'b0000, 64);
        scan(16'hABCD, 4'b0000, 64);
        show(4'hF, 8'hFF, 30);
        mon_en = 1'b0;
        frame_ready = 1'b0;
        chk("ideal_pulses", 16'(mon_pulses), 16'd2);
        chk("ideal_value", mon_value, 16'hABCD);
        chk("ideal_dp", {12'd0, mon_dp}, 16'd0);
        chk("ideal_err", {12'd0, mon_err}, 16'd0);
        @(negedge clk);
        chk("ideal_idle_valid", {15'd0, frame_valid}, 16'd0);

        // Short glitch showing "8" on digit 0 must never be stored.
        show_digit(3, seg_byte(4'h1, 1'b0), 64);
        show_digit(2, seg_byte(4'h2, 1'b0), 64);
        show_digit(1, seg_byte(4'h3, 1'b0), 64);
        show_digit(0, seg_byte(4'h8, 1'b0), 8);
        show(4'hF, 8'hFF, 40);
        chk("glitch_not_complete", {15'd0, frame_valid}, 16'd0);
        show_digit(0, seg_byte(4'h4, 1'b0), 64);
        show(4'hF, 8'hFF, 10);
        wait_valid("glitch_valid");
        check_frame("glitch", 16'h1234, 4'b0000, 4'b0000);
        consume("glitch_consume");

        // Illegal glyph on digit 2.
        show_digit(3, seg_byte(4'h0, 1'b0), 64);
        show_digit(2, 8'hFE, 64);
        show_digit(1, seg_byte(4'h0, 1'b0), 64);
        show_digit(0, seg_byte(4'h0, 1'b0), 64);
        show(4'hF, 8'hFF, 10);
        wait_valid("illegal_valid");
        check_frame("illegal", 16'h0000, 4'b0000, 4'b0100);
        consume("illegal_consume");

        // Back-pressure: second frame dropped, overflow sticks.
        scan(16'h1111, 4'b0000, 64);
        wait_valid("ovf_first_valid");
        chk("ovf_not_yet", {15'd0, overflow}, 16'd0);
        scan(16'h2222, 4'b0000, 64);
        @(negedge clk);
        chk("ovf_held_value", frame_value, 16'h1111);
        chk("ovf_flag", {15'd0, overflow}, 16'd1);
        chk("ovf_still_valid", {15'd0, frame_valid}, 16'd1);
        consume("ovf_consume");
        scan(16'h3333, 4'b0000, 64);
        wait_valid("ovf_next_valid");
        chk("ovf_next_value", frame_value, 16'h3333);
        chk("ovf_sticky", {15'd0, overflow}, 16'd1);
        consume("ovf_next_consume");

        // Blanking gaps and a two-anode ghost step are ignored.
        show_digit(3, seg_byte(4'h0, 1'b0), 64);
        show(4'hF, 8'hFF, 30);
        show(4'b0011, seg_byte(4'h8, 1'b1), 64);
        show_digit(2, seg_byte(4'hF, 1'b0), 64);
        show(4'hF, 8'hFF, 30);
        show_digit(1, seg_byte(4'h0, 1'b0), 64);
        show(4'hF, 8'hFF, 30);
        show_digit(0, seg_byte(4'hF, 1'b0), 64);
        show(4'hF, 8'hFF, 10);
        wait_valid("ghost_valid");
        check_frame("ghost", 16'h0F0F, 4'b0000, 4'b0000);
        consume("ghost_consume");

        // Reset mid-frame discards the partial digits.
        show_digit(3, seg_byte(4'h5, 1'b1), 64);
        show_digit(2, seg_byte(4'h6, 1'b1), 64);
        @(negedge clk);
        chk("midrst_collect", {14'd0, state_dbg}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_overflow", {15'd0, overflow}, 16'd0);
        chk("midrst_value", frame_value, 16'h0000);
        chk("midrst_state", {14'd0, state_dbg}, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        show(4'hF, 8'hFF, 5);
        show_digit(1, seg_byte(4'h7, 1'b0), 64);
        show_digit(0, seg_byte(4'h8, 1'b0), 64);
        show(4'hF, 8'hFF, 40);
        chk("midrst_no_stale_frame", {15'd0, frame_valid}, 16'd0);
        show_digit(3, seg_byte(4'h9, 1'b0), 64);
        show_digit(2, seg_byte(4'hE, 1'b1), 64);
        show(4'hF, 8'hFF, 10);
        wait_valid("midrst_valid");
        check_frame("midrst", 16'h9E78, 4'b0100, 4'b0000);
        consume("midrst_consume");

        // Random frames: random glyphs (occasionally illegal), dp, dwell and digit order.
        for (int f = 0; f < 6; f++) begin
            exp_v = 16'd0;
            exp_err = 4'd0;
            exp_dp = 4'($urandom_range(0, 15));
            for (int d = 0; d < 4; d++) begin
                order[d] = d;
                if ($urandom_range(0, 5) == 0)
                    pat[d] = 7'($urandom_range(0, 127));
                else
                    pat[d] = glyph[$urandom_range(0, 15)];
                found = 1'b0;
                for (int g = 0; g < 16; g++) begin
                    if (!found && glyph[g] == pat[d]) begin
                        found = 1'b1;
                        exp_v[4*d +: 4] = 4'(g);
                    end
                end
                exp_err[d] = !found;
            end
            for (int d = 3; d > 0; d--) begin
                j = $urandom_range(0, d);
                tmp = order[d];
                order[d] = order[j];
                order[j] = tmp;
            end
            for (int d = 0; d < 4; d++) begin
                dwell = $urandom_range(20, 60);
                show_digit(order[d], {~exp_dp[order[d]], ~pat[order[d]]}, dwell);
            end
            show(4'hF, 8'hFF, 10);
            wait_valid("rand_valid");
            check_frame("rand", exp_v, exp_dp, exp_err);
            consume("rand_consume");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
